// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared state encoding and default constants for the pulse sequencer
package pulse_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_PERIOD_C = 3;
    localparam int DEF_HIGH_C   = 1;

endpackage

// File: rtl/pulse_seq_cfg.sv
// rtl/pulse_seq_cfg.sv - config handshake, shadow register and active pattern configuration
module pulse_seq_cfg
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int DEF_HIGH   = DEF_HIGH_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_run,
    input  logic             wrap,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_oneshot,
    output logic [CNT_W-1:0] period_q,
    output logic [CNT_W-1:0] high_q,
    output logic             oneshot_q
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_P = (DEF_PERIOD == 0) ? ONE : CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] RST_H = CNT_W'(DEF_HIGH);

    logic             pending;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_high;
    logic             shadow_oneshot;
    logic             xfer;
    logic [CNT_W-1:0] period_in;

    assign cfg_ready = !pending;
    assign xfer      = cfg_valid && !pending;
    // A zero period would never reach its last count, so it is stored as 1.
    assign period_in = (cfg_period == '0) ? ONE : cfg_period;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending        <= 1'b0;
            shadow_period  <= ONE;
            shadow_high    <= '0;
            shadow_oneshot <= 1'b0;
            period_q       <= RST_P;
            high_q         <= RST_H;
            oneshot_q      <= 1'b0;
        end else begin
            // Apply and accept are exclusive: accept needs !pending, apply needs pending.
            if (wrap && pending) begin
                period_q  <= shadow_period;
                high_q    <= shadow_high;
                oneshot_q <= shadow_oneshot;
                pending   <= 1'b0;
            end
            if (xfer) begin
                if (in_run) begin
                    shadow_period  <= period_in;
                    shadow_high    <= cfg_high;
                    shadow_oneshot <= cfg_oneshot;
                    pending        <= 1'b1;
                end else begin
                    period_q  <= period_in;
                    high_q    <= cfg_high;
                    oneshot_q <= cfg_oneshot;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// rtl/pulse_sequencer.sv - periodic / one-shot pulse pattern generator with shadowed config
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int DEF_HIGH   = DEF_HIGH_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_oneshot,
    output logic             out,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             oneshot_q;
    logic             last;

    pulse_seq_cfg #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_HIGH   (DEF_HIGH)
    ) u_cfg (
        .clk         (clk),
        .reset       (reset),
        .in_run      (state_q == ST_RUN),
        .wrap        (wrap),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_oneshot (cfg_oneshot),
        .period_q    (period_q),
        .high_q      (high_q),
        .oneshot_q   (oneshot_q)
    );

    // period_q is never 0, so the subtraction cannot underflow.
    assign last  = (count_q == (period_q - ONE));
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        out     = 1'b0;
        busy    = 1'b0;
        wrap    = 1'b0;
        if (state_q == ST_RUN) begin
            busy = 1'b1;
            out  = (count_q < high_q);
            wrap = enable && last;
            if (enable) begin
                if (last) begin
                    count_d = '0;
                    if (oneshot_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end
        end else begin
            count_d = '0;
            if (start) begin
                state_d = ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb/tb_pulse_sequencer.sv - directed scoreboard bench for pulse_sequencer
module tb_pulse_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_oneshot = 1'b0;
    logic       out;
    logic [7:0] count;
    logic       wrap;
    logic       busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic       out;
        logic [7:0] count;
        logic       wrap;
        logic       busy;
        logic       rdy;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pulse_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .start       (start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_oneshot (cfg_oneshot),
        .out         (out),
        .count       (count),
        .wrap        (wrap),
        .busy        (busy)
    );

    task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s.%s got %0d expected %0d", tag, fld, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic s, input logic cv,
                        input logic [7:0] p, input logic [7:0] h, input logic os,
                        input logic xo, input logic [7:0] xc, input logic xw,
                        input logic xb, input logic xr);
        exp_t x;
        exp_t y;
        @(negedge clk);
        enable      = e;
        start       = s;
        cfg_valid   = cv;
        cfg_period  = p;
        cfg_high    = h;
        cfg_oneshot = os;
        x.tag = tag; x.out = xo; x.count = xc; x.wrap = xw; x.busy = xb; x.rdy = xr;
        sb.push_back(x);
        #1;
        y = sb.pop_front();
        chk(y.tag, "out",   {7'd0, out},       {7'd0, y.out});
        chk(y.tag, "count", count,             y.count);
        chk(y.tag, "wrap",  {7'd0, wrap},      {7'd0, y.wrap});
        chk(y.tag, "busy",  {7'd0, busy},      {7'd0, y.busy});
        chk(y.tag, "ready", {7'd0, cfg_ready}, {7'd0, y.rdy});
    endtask

    task automatic r(input string tag, input logic xo, input logic [7:0] xc,
                     input logic xw, input logic xb, input logic xr);
        step(tag, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, xo, xc, xw, xb, xr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // defaults: period 3, high 1
        r("def0", 1, 0, 0, 1, 1);
        r("def1", 0, 1, 0, 1, 1);
        r("def2", 0, 2, 1, 1, 1);
        r("def3", 1, 0, 0, 1, 1);
        r("def4", 0, 1, 0, 1, 1);
        r("def5", 0, 2, 1, 1, 1);

        // shadowed update in RUN, second offer while pending is refused
        r("sh0", 1, 0, 0, 1, 1);
        step("sh_offer", 1, 0, 1, 8'd5, 8'd2, 0, 0, 1, 0, 1, 1);
        step("sh_busy",  1, 0, 1, 8'd7, 8'd7, 1, 0, 2, 1, 1, 0);
        r("p5_0", 1, 0, 0, 1, 1);
        r("p5_1", 1, 1, 0, 1, 1);
        r("p5_2", 0, 2, 0, 1, 1);
        r("p5_3", 0, 3, 0, 1, 1);
        r("p5_4", 0, 4, 1, 1, 1);

        // enable low holds everything and suppresses wrap
        r("en_0", 1, 0, 0, 1, 1);
        step("hold_a", 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, 0, 1, 1);
        step("hold_b", 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, 0, 1, 1);
        step("hold_c", 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, 0, 1, 1);
        r("en_1", 1, 1, 0, 1, 1);
        r("en_2", 0, 2, 0, 1, 1);
        r("en_3", 0, 3, 0, 1, 1);
        step("hold_last", 0, 0, 0, 8'd0, 8'd0, 0, 0, 4, 0, 1, 1);
        r("en_4", 0, 4, 1, 1, 1);

        // pending one-shot at a free-run wrap: one more period, then IDLE
        step("os_offer", 1, 0, 1, 8'd4, 8'd1, 1, 1, 0, 0, 1, 1);
        r("os_a1", 1, 1, 0, 1, 0);
        r("os_a2", 0, 2, 0, 1, 0);
        r("os_a3", 0, 3, 0, 1, 0);
        r("os_a4", 0, 4, 1, 1, 0);
        r("os_b0", 1, 0, 0, 1, 1);
        r("os_b1", 0, 1, 0, 1, 1);
        r("os_b2", 0, 2, 0, 1, 1);
        r("os_b3", 0, 3, 1, 1, 1);
        r("idle0", 0, 0, 0, 0, 1);
        r("idle1", 0, 0, 0, 0, 1);
        step("start_en0", 0, 1, 0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 1);
        r("os_c0", 1, 0, 0, 1, 1);
        r("os_c1", 0, 1, 0, 1, 1);
        r("os_c2", 0, 2, 0, 1, 1);
        r("os_c3", 0, 3, 1, 1, 1);
        r("idle2", 0, 0, 0, 0, 1);

        // IDLE config with same-cycle start; period 0 treated as 1
        step("p0_start", 1, 1, 1, 8'd0, 8'd1, 0, 0, 0, 0, 0, 1);
        r("p1_a", 1, 0, 1, 1, 1);
        r("p1_b", 1, 0, 1, 1, 1);
        r("p1_c", 1, 0, 1, 1, 1);
        step("p255_offer", 1, 0, 1, 8'd255, 8'd0, 0, 1, 0, 1, 1, 1);
        r("p1_pend", 1, 0, 1, 1, 0);
        r("p255_0", 0, 0, 0, 1, 1);
        for (int i = 1; i < 254; i++) begin
            r("p255_mid", 0, 8'(i), 0, 1, 1);
        end
        r("p255_254", 0, 254, 1, 1, 1);
        r("p255_wrap", 0, 0, 0, 1, 1);

        // reset mid-run discards the pending config
        r("rs_pre1", 0, 1, 0, 1, 1);
        step("rs_offer", 1, 0, 1, 8'd6, 8'd3, 0, 0, 2, 0, 1, 1);
        r("rs_pend", 0, 3, 0, 1, 0);
        do_reset();
        r("rs0", 1, 0, 0, 1, 1);
        r("rs1", 0, 1, 0, 1, 1);
        r("rs2", 0, 2, 1, 1, 1);
        r("rs3", 1, 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
